// File: rtl/uart_echo_tx_if.sv
// Enqueue-side bus of the UART echo transmitter: byte strobe in, FIFO status out.
interface uart_echo_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;

    modport master (
        output i_data,
        output i_valid,
        input  o_full,
        input  o_empty,
        input  o_overflow
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_full,
        output o_empty,
        output o_overflow
    );
endinterface

// File: rtl/uart_echo_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back-to-back while
// bytes are queued, and the serial line is driven straight from a flop.
module uart_echo_tx #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 3
) (
    input  logic            CLK_i,
    input  logic            RST_N_i,
    uart_echo_tx_if.slave   enq,
    output logic            o_busy,
    output logic            UART_TX
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0]      BAUD_LAST = CW'(DIV - 1);
    localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW + 1){1'b0}};
    localparam logic [CW-1:0]      BAUD_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_s;
    logic               full_r;
    logic               empty_r;
    logic               ovf_r;
    logic               wr_en_s;
    logic               pop_s;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      baud_r;
    logic [CW-1:0]      baud_s;
    logic [2:0]         bit_idx_r;
    logic [2:0]         bit_idx_s;
    logic [7:0]         shreg_r;
    logic [7:0]         shreg_s;
    logic               tx_r;
    logic               tx_s;
    logic               busy_r;
    logic               bit_done_s;

    // A full FIFO drops the write even when a pop frees a slot on the same edge.
    assign wr_en_s    = enq.i_valid & ~full_r;
    assign bit_done_s = (baud_r == BAUD_LAST);

    // Occupancy update for write/pop combinations.
    always_comb begin
        count_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_s = count_r + (FIFO_AW + 1)'(1'b1);
            2'b01:   count_s = count_r - (FIFO_AW + 1)'(1'b1);
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; contents are dropped by resetting the pointers, not the array.
    always_ff @(posedge CLK_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= enq.i_data;
        end
    end

    // FIFO pointers, occupancy flags and the overflow pulse.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            ovf_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
            empty_r <= (count_s == CNT_ZERO);
            ovf_r   <= enq.i_valid & full_r;
        end
    end

    // Frame sequencer: next state, baud/bit counters, shift register and line level.
    always_comb begin
        state_s   = state_r;
        baud_s    = baud_r;
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_s    = BAUD_ZERO;
                bit_idx_s = 3'd0;
                if (!empty_r) begin
                    pop_s   = 1'b1;
                    shreg_s = mem_r[rd_ptr_r];
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    baud_s    = BAUD_ZERO;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    baud_s = baud_r + CW'(1'b1);
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    baud_s = BAUD_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shreg_s   = {1'b0, shreg_r[7:1]};
                    end
                end else begin
                    baud_s = baud_r + CW'(1'b1);
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    baud_s = BAUD_ZERO;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!empty_r) begin
                        pop_s   = 1'b1;
                        shreg_s = mem_r[rd_ptr_r];
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + CW'(1'b1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                baud_s    = BAUD_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase

        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shreg_s[0];
            default:  tx_s = 1'b1;
        endcase
    end

    // Sequencer state and the registered line/busy outputs.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_r   <= ST_IDLE;
            baud_r    <= BAUD_ZERO;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
            tx_r      <= tx_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign enq.o_full     = full_r;
    assign enq.o_empty    = empty_r;
    assign enq.o_overflow = ovf_r;
    assign o_busy         = busy_r;
    assign UART_TX        = tx_r;

endmodule
